// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 key schedule blocks.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StServe
  } state_e;

  // Round constant for rounds 1..10; other indices are never used.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    unique case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four forward S-box lookups on a 32-bit word.
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = Sbox[word_i[8*b +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_sched_inv.sv
// Iterative AES-128 key expansion; stores all 11 round keys and serves them
// round 10 down to round 0, one per consumer request.
module aes_key_sched_inv
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] KEY,
  output logic          busy,
  output logic          key_ready,
  input  logic          rk_next,
  output logic [KW-1:0] RK,
  output logic [3:0]    RK_round,
  output logic          rk_last
);

  localparam logic [3:0] LastRound = 4'(NR);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          key_ready_q, key_ready_d;
  logic [KW-1:0] rk_q, rk_d;
  logic [3:0]    rk_round_q, rk_round_d;

  // Round-key store; contents are don't-care after reset, so no reset here.
  logic [KW-1:0] w_q [NR+1];
  logic          w_we;
  logic [3:0]    w_idx;
  logic [KW-1:0] w_wdata;

  logic [3:0]    prev_idx;
  logic [KW-1:0] prev;
  logic [31:0]   sub_word;
  logic [31:0]   t_word;
  logic [31:0]   word0, word1, word2, word3;
  logic [KW-1:0] w_new;
  logic [3:0]    serve_idx;

  assign prev_idx  = cnt_q - 4'd1;
  assign prev      = w_q[prev_idx];
  assign serve_idx = rk_round_q - 4'd1;

  aes_subword u_subword (
    .word_i ({prev[23:0], prev[31:24]}),
    .word_o (sub_word)
  );

  always_comb begin
    t_word = sub_word ^ {rcon(cnt_q), 24'h0};
    word0  = prev[127:96] ^ t_word;
    word1  = prev[95:64]  ^ word0;
    word2  = prev[63:32]  ^ word1;
    word3  = prev[31:0]   ^ word2;
    w_new  = {word0, word1, word2, word3};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    key_ready_d = key_ready_q;
    rk_d        = rk_q;
    rk_round_d  = rk_round_q;
    w_we        = 1'b0;
    w_idx       = 4'd0;
    w_wdata     = KEY;

    // start wins over rk_next in SERVE, so it is decoded first.
    if (start && (state_q != StExpand)) begin
      w_we        = 1'b1;
      w_idx       = 4'd0;
      w_wdata     = KEY;
      cnt_d       = 4'd1;
      busy_d      = 1'b1;
      key_ready_d = 1'b0;
      rk_d        = '0;
      rk_round_d  = 4'd0;
      state_d     = StExpand;
    end else begin
      unique case (state_q)
        StExpand: begin
          w_we    = 1'b1;
          w_idx   = cnt_q;
          w_wdata = w_new;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LastRound) begin
            busy_d      = 1'b0;
            key_ready_d = 1'b1;
            rk_d        = w_new;
            rk_round_d  = LastRound;
            state_d     = StServe;
          end
        end
        StServe: begin
          if (rk_next) begin
            if (rk_round_q != 4'd0) begin
              rk_d       = w_q[serve_idx];
              rk_round_d = serve_idx;
            end else begin
              key_ready_d = 1'b0;
              rk_d        = '0;
              state_d     = StIdle;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_q        <= '0;
      rk_round_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      rk_q        <= rk_d;
      rk_round_q  <= rk_round_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_we) begin
      w_q[w_idx] <= w_wdata;
    end
  end

  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign RK        = rk_q;
  assign RK_round  = rk_round_q;
  assign rk_last   = key_ready_q && (rk_round_q == 4'd0);

endmodule

// File: tb/tb_aes_key_sched_inv.sv
// Randomised self-checking bench: a word-level FIPS-197 key expansion model
// (S-box derived from GF(2^8) inversion) predicts every output cycle by cycle.
module tb_aes_key_sched_inv;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] KEY;
  logic         busy;
  logic         key_ready;
  logic         rk_next;
  logic [127:0] RK;
  logic [3:0]   RK_round;
  logic         rk_last;

  aes_key_sched_inv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .KEY       (KEY),
    .busy      (busy),
    .key_ready (key_ready),
    .rk_next   (rk_next),
    .RK        (RK),
    .RK_round  (RK_round),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   tb_sbox [256];
  logic [127:0] ks [11];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      end
      tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  logic [127:0] m_keys [11];
  bit           mvalid = 0;
  bit           m_busy = 0;
  bit           m_ready = 0;
  bit           m_zero = 1;
  int           m_left = 0;
  int           m_round = 0;

  always @(posedge clk) begin
    if (!reset) begin
      mvalid  = 1;
      m_busy  = 0;
      m_ready = 0;
      m_zero  = 1;
      m_round = 0;
    end else if (mvalid) begin
      if (start && !m_busy) begin
        expand_key(KEY);
        for (int r = 0; r < 11; r++) m_keys[r] = ks[r];
        m_busy  = 1;
        m_ready = 0;
        m_zero  = 0;
        m_left  = 10;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 0;
          m_ready = 1;
          m_round = 10;
        end
      end else if (m_ready && rk_next) begin
        if (m_round > 0) m_round--;
        else begin
          m_ready = 0;
          m_zero  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("key_ready", 128'(key_ready), 128'(m_ready));
      check("rk_last", 128'(rk_last), 128'(m_ready && m_round == 0));
      if (m_ready) begin
        check("RK", RK, m_keys[m_round]);
        check("RK_round", 128'(RK_round), 128'(m_round));
      end else if (m_zero) begin
        check("RK_zero", RK, 128'h0);
        check("RK_round_zero", 128'(RK_round), 128'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] KeyA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Launch start at the next edge, then confirm busy for 9 cycles and ready after t10.
  task automatic run_expand(input logic [127:0] key, input string nm);
    KEY   = key;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 10) check({nm, "_busy"}, 128'(busy), 128'd1);
      else        check({nm, "_ready"}, 128'(key_ready), 128'd1);
    end
  endtask

  initial begin
    logic [127:0] nk;
    reset   = 1'b0;
    start   = 1'b1;
    rk_next = 1'b0;
    KEY     = KeyA;

    build_sbox();
    expand_key(KeyA);
    check("model_A_r10", ks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_A_r9", ks[9], 128'h549932d1f08557681093ed9cbe2c974e);
    check("model_A_r1", ks[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    expand_key(KeyB);
    check("model_B_r10", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset held with start asserted.
    cyc();
    cyc();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_RK", RK, 128'h0);
    reset = 1'b1;
    start = 1'b0;
    cyc();

    // Known-answer expansion and full serve with rk_next held high.
    run_expand(KeyA, "A");
    check("A_RK10", RK, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("A_round10", 128'(RK_round), 128'd10);
    rk_next = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 1)  check("A_RK9", RK, 128'h549932d1f08557681093ed9cbe2c974e);
      if (k == 9)  check("A_RK1", RK, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      if (k == 10) begin
        check("A_RK0", RK, KeyA);
        check("A_rk_last", 128'(rk_last), 128'd1);
      end
      if (k == 11) check("A_done", 128'(key_ready), 128'd0);
    end
    rk_next = 1'b0;
    cyc();

    // Second known key, requests on alternate cycles.
    run_expand(KeyB, "B");
    check("B_RK10", RK, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int k = 0; k < 12; k++) begin
      rk_next = k[0];
      cyc();
    end
    rk_next = 1'b0;

    // Reset mid-expansion, then the A key again.
    KEY   = KeyA;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    reset = 1'b0;
    cyc();
    check("midrst_busy", 128'(busy), 128'd0);
    reset = 1'b1;
    run_expand(KeyA, "A2");
    check("A2_RK10", RK, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Restart from SERVE at round 6 with rk_next also high.
    rk_next = 1'b1;
    repeat (4) cyc();
    check("pre_restart_round", 128'(RK_round), 128'd6);
    nk    = {$urandom, $urandom, $urandom, $urandom};
    KEY   = nk;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_busy", 128'(busy), 128'd1);
    check("restart_ready", 128'(key_ready), 128'd0);
    repeat (10) cyc();
    expand_key(nk);
    check("restart_RK10", RK, ks[10]);
    check("restart_round", 128'(RK_round), 128'd10);
    rk_next = 1'b0;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 39) == 0);
      rk_next = $urandom_range(0, 1) == 1;
      KEY     = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    reset   = 1'b1;
    start   = 1'b0;
    rk_next = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
